// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU front-end types and constants.
//   virt_t        - 32-bit virtual address
//   fetch_entry_t - one fetched instruction slot: pc, instruction word, and
//                   an address-error flag raised for misaligned fetch targets
//   FETCH_WIDTH   - words per fetch group (one 16-byte aligned block)
package cpu_defs;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        virt_t       pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    localparam int FETCH_WIDTH = 4;

    // Number of words a group fetched at pc delivers: from pc up to the end
    // of its 16-byte block.
    function automatic logic [2:0] group_words(input virt_t pc);
        return 3'(FETCH_WIDTH) - {1'b0, pc[3:2]};
    endfunction

endpackage

// File: rtl/cpu_ibus_if.sv
// cpu_ibus_if: three-stage instruction bus between the fetch unit (master)
// and the instruction cache.
//   read, address      - IF1 request, held stable while stall is high
//   flush_1, flush_2   - discard whatever is in the bus IF2/IF3 stages
//   stall              - IF2 lookup not finished, pipeline holds
//   rddata/_extra      - IF3 fetch-group data, word i at bits [32i+31:32i]
interface cpu_ibus_if;

    logic        read;
    logic [31:0] address;
    logic        flush_1;
    logic        flush_2;
    logic        stall;
    logic [63:0] rddata;
    logic [63:0] rddata_extra;

    modport master (
        output read, address, flush_1, flush_2,
        input  stall, rddata, rddata_extra
    );

endinterface

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of fetch entries.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous flush; wins over push and pop
//   push_num    - number of entries (0..4) taken from push_data[0..]
//   push_data   - entries to write, lowest index first
//   pop_num     - entries consumed this cycle (0..2), clamped to count
//   count       - occupancy before this cycle's push/pop
//   head0/head1 - entry at head and head+1 (only meaningful when count allows)
module instr_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [2:0]                        push_num,
    input  fetch_entry_t [FETCH_WIDTH-1:0]    push_data,
    input  logic [1:0]                        pop_num,
    output logic [$clog2(DEPTH):0]            count,
    output fetch_entry_t                      head0,
    output fetch_entry_t                      head1
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr_next;
    logic [1:0]     pop_eff;

    // A consumer asking for more than is stored must not corrupt the count.
    always_comb begin
        pop_eff = pop_num;
        if ((AW+1)'(pop_num) > count) begin
            pop_eff = count[1:0];
        end
        rd_ptr_next = rd_ptr + AW'(1);
        head0 = mem[rd_ptr];
        head1 = mem[rd_ptr_next];
    end

    // Storage has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!clear && (3'(i) < push_num)) begin
                mem[wr_ptr + AW'(i)] <= push_data[i];
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_num);
            rd_ptr <= rd_ptr + AW'(pop_eff);
            count  <= count + (AW+1)'(push_num) - (AW+1)'(pop_eff);
        end
    end

    // The fetch unit's credit scheme is what keeps this from overflowing.
    assert property (@(posedge clk) disable iff (!rst_n)
        clear || ((int'(count) + int'(push_num) - int'(pop_eff)) <= DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC generation and instruction-bus master.
//   clk, rst_n      - clock, asynchronous active-low reset
//   ibus            - cpu_ibus_if master port (IF1 request, IF2 stall, IF3 data)
//   redirect_valid  - branch/exception redirect from the backend
//   redirect_pc     - redirect target
//   deq_num         - entries decode takes this cycle (0..2)
//   out_valid       - bit0: out_entry0 valid, bit1: out_entry1 valid
//   out_entry0/1    - queue head and head+1
module instr_fetch
    import cpu_defs::*;
#(
    parameter int    QUEUE_DEPTH = 16,
    parameter virt_t RESET_PC    = 32'hbfc0_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_ibus_if.master    ibus,
    input  logic          redirect_valid,
    input  virt_t         redirect_pc,
    input  logic [1:0]    deq_num,
    output logic [1:0]    out_valid,
    output fetch_entry_t  out_entry0,
    output fetch_entry_t  out_entry1
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    virt_t          pc;
    logic           halted;
    logic           adel_pend;
    logic           if2_v;
    virt_t          if2_pc;
    logic           if3_v;
    virt_t          if3_pc;
    logic [CW-1:0]  count;
    logic           credit_ok;
    logic           read;
    logic           accept;
    logic [127:0]   group_data;
    logic [2:0]     push_num;
    fetch_entry_t [FETCH_WIDTH-1:0] push_data;

    // Every group in flight reserves a full FETCH_WIDTH slots, so a request
    // is only issued once the queue is sure to hold everything outstanding.
    // halted also covers the cycle where the address-error entry is pending.
    always_comb begin
        credit_ok = (int'(count) + FETCH_WIDTH * (int'(if2_v) + int'(if3_v) + 1))
                    <= QUEUE_DEPTH;
        read      = rst_n & ~redirect_valid & ~halted & credit_ok;
        accept    = read & ~ibus.stall;
    end

    assign ibus.read    = read;
    assign ibus.address = pc;
    assign ibus.flush_1 = redirect_valid;
    assign ibus.flush_2 = redirect_valid;

    // PC and bus-stage tags. A redirect discards both bus stages regardless
    // of stall; a misaligned target never reaches the bus and instead raises
    // one address-error entry, then parks the unit until the next redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            halted    <= 1'b0;
            adel_pend <= 1'b0;
            if2_v     <= 1'b0;
            if2_pc    <= RESET_PC;
            if3_v     <= 1'b0;
            if3_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            halted    <= |redirect_pc[1:0];
            adel_pend <= |redirect_pc[1:0];
            if2_v     <= 1'b0;
            if3_v     <= 1'b0;
        end else begin
            adel_pend <= 1'b0;
            if (accept) begin
                pc <= {pc[31:4], 4'b0000} + 32'd16;
            end
            if (!ibus.stall) begin
                if3_v  <= if2_v;
                if3_pc <= if2_pc;
                if2_v  <= accept;
                if (accept) begin
                    if2_pc <= pc;
                end
            end else begin
                if3_v <= 1'b0;
            end
        end
    end

    // Queue writes: either the IF3 group (only the words from if3_pc to the
    // end of its block) or the single address-error entry.
    always_comb begin
        group_data = {ibus.rddata_extra, ibus.rddata};
        push_num   = 3'd0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            push_data[i].pc    = if3_pc + virt_t'(4 * i);
            push_data[i].instr = group_data[32*i +: 32];
            push_data[i].adel  = 1'b0;
        end
        if (adel_pend) begin
            push_num           = 3'd1;
            push_data[0].pc    = pc;
            push_data[0].instr = '0;
            push_data[0].adel  = 1'b1;
        end else if (if3_v) begin
            push_num = group_words(if3_pc);
        end
    end

    instr_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push_num  (push_num),
        .push_data (push_data),
        .pop_num   (deq_num),
        .count     (count),
        .head0     (out_entry0),
        .head1     (out_entry1)
    );

    assign out_valid = {count >= CW'(2), count != '0};

endmodule
